// File: rtl/mul_pkg.sv
// Shared types and constants for the iterative multiplier.
package mul_pkg;

    typedef enum logic [1:0] {
        MUL_LO  = 2'b00,
        MUL_HSS = 2'b01,
        MUL_HSU = 2'b10,
        MUL_HUU = 2'b11
    } mul_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10,
        DONE = 2'b11
    } mul_state_e;

    localparam int MUL_ITER = 32;

endpackage

// File: rtl/adder_32bit.sv
// 32-bit ripple-carry adder; one full-adder cell per bit.
module adder_32bit (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);

    logic [32:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < 32; i++) begin : g_fa
        assign sum[i]       = a[i] ^ b[i] ^ carry[i];
        assign carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end

    assign cout = carry[32];

endmodule

// File: rtl/seq_multiplier.sv
// Iterative 32x32 shift-add multiplier for MUL/MULH/MULHSU/MULHU.
// Magnitudes are multiplied unsigned; the sign is restored in FIX.
// Optional macro SEQ_MUL_ZERO_BYPASS_EN: a zero operand skips CALC/FIX
// and reports result 0 one cycle after acceptance.
//
// state | meaning
// IDLE  | ready=1, waiting for start
// CALC  | 32 shift-add steps on {hi, lo}
// FIX   | optional 64-bit negate, select result word
// DONE  | done=1 for one cycle
module seq_multiplier
    import mul_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            ready,
    output logic            done,
    output logic [XLEN-1:0] result
);

    mul_state_e       state;
    mul_op_e          op_q;
    mul_op_e          op_in;
    logic [XLEN-1:0]  mcand;
    logic [XLEN-1:0]  hi;
    logic [XLEN-1:0]  lo;
    logic [CNT_W-1:0] cnt;
    logic             neg;

    logic             sign_a;
    logic             sign_b;
    logic [XLEN-1:0]  abs_a;
    logic [XLEN-1:0]  abs_b;
    logic [XLEN-1:0]  add_b;
    logic [XLEN-1:0]  add_sum;
    logic             add_cout;
    logic [2*XLEN-1:0] prod_fix;

    // Operand conditioning at acceptance and the sign-restored product.
    always_comb begin
        op_in    = mul_op_e'(op);
        sign_a   = ((op_in == MUL_HSS) || (op_in == MUL_HSU)) && op_a[XLEN-1];
        sign_b   = (op_in == MUL_HSS) && op_b[XLEN-1];
        abs_a    = sign_a ? (~op_a + 32'd1) : op_a;
        abs_b    = sign_b ? (~op_b + 32'd1) : op_b;
        add_b    = lo[0] ? mcand : '0;
        prod_fix = neg ? (~{hi, lo} + 64'd1) : {hi, lo};
    end

    // Adding zero when lo[0]=0 yields {0, hi}, so one adder covers both cases.
    adder_32bit u_adder (
        .a    (hi),
        .b    (add_b),
        .cin  (1'b0),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // Sequencer, datapath registers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            op_q   <= MUL_LO;
            mcand  <= '0;
            hi     <= '0;
            lo     <= '0;
            cnt    <= '0;
            neg    <= 1'b0;
            ready  <= 1'b1;
            done   <= 1'b0;
            result <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q  <= op_in;
                        mcand <= abs_a;
                        hi    <= '0;
                        lo    <= abs_b;
                        neg   <= sign_a ^ sign_b;
                        cnt   <= '0;
                        ready <= 1'b0;
`ifdef SEQ_MUL_ZERO_BYPASS_EN
                        if ((op_a == '0) || (op_b == '0)) begin
                            result <= '0;
                            done   <= 1'b1;
                            state  <= DONE;
                        end else begin
                            state <= CALC;
                        end
`else
                        state <= CALC;
`endif
                    end
                end
                CALC: begin
                    hi  <= {add_cout, add_sum[XLEN-1:1]};
                    lo  <= {add_sum[0], lo[XLEN-1:1]};
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(MUL_ITER - 1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    result <= (op_q == MUL_LO) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
                    done   <= 1'b1;
                    state  <= DONE;
                end
                DONE: begin
                    done  <= 1'b0;
                    ready <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_multiplier.sv
// Scoreboard bench for seq_multiplier: expectations are queued at
// acceptance and compared (value and latency) when done pulses.
module tb_seq_multiplier;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        ready;
    logic        done;
    logic [31:0] result;

    seq_multiplier dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .op_a   (op_a),
        .op_b   (op_b),
        .ready  (ready),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        int          acc;
        int          lat;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_done   = 0;
    int   n_acc    = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea;
        logic [63:0] eb;
        logic [63:0] p;
        ea = (o == 2'b01 || o == 2'b10) ? {{32{a[31]}}, a} : {32'b0, a};
        eb = (o == 2'b01) ? {{32{b[31]}}, b} : {32'b0, b};
        p  = ea * eb;
        return (o == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    function automatic int exp_lat(input logic [31:0] a, input logic [31:0] b);
`ifdef SEQ_MUL_ZERO_BYPASS_EN
        if (a == 0 || b == 0) return 1;
`endif
        return 34;
    endfunction

    // Pop and compare on every done pulse.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                check($sformatf("result_%0d", n_done), {32'b0, result}, {32'b0, e.res});
                check($sformatf("latency_%0d", n_done), 64'(cyc - e.acc), 64'(e.lat));
                n_done++;
            end
        end
    end

    // Called at a negedge; returns at the negedge after acceptance.
    task automatic issue_exp(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] exp);
        int t = 0;
        while (!ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!ready) check("ready_timeout", 64'd0, 64'd1);
        op    = o;
        op_a  = a;
        op_b  = b;
        start = 1'b1;
        exp_q.push_back('{res: exp, acc: cyc, lat: exp_lat(a, b)});
        n_acc++;
        @(negedge clk);
        start = 1'b0;
        op    = 2'($urandom);
        op_a  = $urandom;
        op_b  = $urandom;
    endtask

    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        issue_exp(o, a, b, model(o, a, b));
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (exp_q.size() != 0) begin
            check("drain_timeout", 64'(exp_q.size()), 64'd0);
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("reset_ready", {63'b0, ready}, 64'd1);
        check("reset_done", {63'b0, done}, 64'd0);
        check("reset_result", {32'b0, result}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        issue_exp(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        issue_exp(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
        issue_exp(2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
        issue_exp(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000);
        issue_exp(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        issue_exp(2'b00, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
        drain();

        // Starts during busy and in the done cycle are ignored; cycle 35 re-accepts.
        issue_exp(2'b00, 32'd11, 32'd13, 32'd143);
        for (int c = 1; c <= 35; c++) begin
            check($sformatf("busy_ready_c%0d", c), {63'b0, ready}, (c <= 34) ? 64'd0 : 64'd1);
            if (c == 5 || c == 34) begin
                op    = 2'b11;
                op_a  = 32'hDEAD_BEEF;
                op_b  = 32'h1234_5678;
                start = 1'b1;
            end else if (c == 35) begin
                op    = 2'b00;
                op_a  = 32'd6;
                op_b  = 32'd7;
                start = 1'b1;
                exp_q.push_back('{res: 32'd42, acc: cyc, lat: 34});
                n_acc++;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        drain();

        // Reset in the middle of CALC aborts the operation.
        issue(2'b00, 32'h1234, 32'h5678);
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_ready", {63'b0, ready}, 64'd1);
        check("abort_done", {63'b0, done}, 64'd0);
        check("abort_result", {32'b0, result}, 64'd0);
        exp_q.delete();
        n_acc--;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        issue_exp(2'b00, 32'd3, 32'd5, 32'h0000_000F);
        drain();

        issue_exp(2'b00, 32'd0, 32'h1234, 32'd0);
        drain();

        for (int i = 0; i < 8; i++) begin
            issue(2'($urandom), $urandom, $urandom);
        end
        drain();

        check("done_count", 64'(n_done), 64'(n_acc));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_multiplier.md
Name: seq_multiplier

Overview:
- Iterative 32x32 multiplier for the M-extension multiply group (MUL, MULH, MULHSU, MULHU).
- Consumes the 32-bit ripple adder: one adder_32bit instance performs one shift-add step per cycle, and its {cout, sum} feeds the partial-product register.
- Sits beside the ALU in the execute stage; the core stalls on ready/done.

Parameters:
- XLEN, 32, operand width; only 32 is supported (adder is fixed 32-bit).
- CNT_W, 6, iteration counter width (must hold 0..32).

Ports:
- clk  input  1  core clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only when ready=1
- op  input  2  00 MUL (low word), 01 MULH (signed x signed, high word), 10 MULHSU (signed x unsigned, high word), 11 MULHU (unsigned x unsigned, high word)
- op_a  input  32  multiplicand (rs1)
- op_b  input  32  multiplier (rs2)
- ready  output  1  high in IDLE only
- done  output  1  single-cycle pulse; result valid
- result  output  32  selected product word; held until next accepted start

Behaviour:
- Reset (async, rst_n=0): state IDLE, ready=1, done=0, result=0, counter=0, product register=0. Reset mid-operation aborts with no done pulse.
- States: IDLE -> CALC -> FIX -> DONE -> IDLE.
- IDLE, start=1 (cycle 0):
  - Latch op.
  - Latch |op_a| and |op_b| according to signedness (MULH: both signed; MULHSU: a signed; MUL/MULHU: unsigned; MUL low word is sign-agnostic).
  - Latch neg = sign_a XOR sign_b for the signed operands.
  - Product register {hi=0, lo=|op_b|}; counter=0; go to CALC.
- CALC, 32 cycles (cycles 1..32):
  - If lo[0]: {c, s} = hi + mcand via adder_32bit with cin=0; else {c, s} = {0, hi}.
  - Shift {c, s, lo} right by 1.
  - counter++; after the 32nd step go to FIX.
- |op| of 0x80000000 is 0x80000000, which is representable unsigned; no overflow case.
- FIX (cycle 33): if neg, product = two's-complement 64-bit negate. result <= op==MUL ? product[31:0] : product[63:32]. Go to DONE.
- DONE (cycle 34): done=1 for exactly one cycle; next cycle IDLE.
- Latency: done is high 34 cycles after the start-accept cycle.
- start while not ready is ignored; op_a/op_b/op changes after acceptance have no effect.
- start in the same cycle as done is ignored (ready=0 in DONE); the earliest re-accept is the cycle after done.

Optional Feature:
- Macro: SEQ_MUL_ZERO_BYPASS_EN.
- Defined: if op_a==0 or op_b==0 at acceptance, skip CALC/FIX and go IDLE -> DONE directly. result=0 and done pulses in cycle 1.
- Undefined: zero operands take the full 34-cycle path and still yield 0.
- No other behaviour differs.

Decomposition:
- Package mul_pkg:
  - typedef enum logic [1:0] mul_op_e {MUL_LO, MUL_HSS, MUL_HSU, MUL_HUU}
  - typedef enum logic [1:0] mul_state_e {IDLE, CALC, FIX, DONE}
  - localparam MUL_ITER = 32
- Sub-module: instantiate the existing adder_32bit for the step add; no new sub-module.
- The final negate is an inline 64-bit expression.

Test Plan:
- MULHU 0xFFFFFFFF x 0xFFFFFFFF -> done at cycle 34, result 0xFFFFFFFE; MUL same operands -> 0x00000001.
- MULH 0x80000000 x 0x80000000 -> 0x40000000; MULH 0xFFFFFFFF x 0xFFFFFFFF (-1 x -1) -> 0x00000000.
- MULHSU op_a=0xFFFFFFFF (-1), op_b=0xFFFFFFFF -> 0xFFFFFFFF; MUL 7 x -3 (0xFFFFFFFD) -> 0xFFFFFFEB.
- start pulsed in cycles 5 and 34 with different operands -> only the first accepted, exactly one done pulse; ready low cycles 1..34, re-accept allowed at cycle 35.
- rst_n dropped at cycle 10 of CALC -> immediate IDLE, ready=1, result=0, no done; a new MUL 3 x 5 then returns 0x0000000F.
- Zero operand MUL 0 x 0x1234: with SEQ_MUL_ZERO_BYPASS_EN done at cycle 1, without it done at cycle 34; result 0 in both.
